// File: rtl/rr_stream_mux_if.sv
// rr_stream_mux_if: stream bundle shared by the N producers and the
// single consumer of rr_stream_mux.
interface rr_stream_mux_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4
);
   localparam int SEL_W = (N > 2) ? $clog2(N) : 1;

   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic [N-1:0]       ch_en;
   logic               prio_mode;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]   out_sel;
   logic               out_ready;

   modport master (
      output in_valid, in_data, ch_en, prio_mode, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data, ch_en, prio_mode, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-input stream funnel with round-robin or fixed
// priority arbitration and a registered output stage.
module rr_stream_mux #(
   parameter int WIDTH = 8,
   parameter int N     = 4
) (
   input  logic           clk,
   input  logic           rst,
   rr_stream_mux_if.slave bus
);
   localparam int SEL_W = (N > 2) ? $clog2(N) : 1;
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] win;
   logic             found;
   logic [N-1:0]     req;
   logic             load_en;
   logic [WIDTH-1:0] pick;
   logic             valid_q;
   logic [WIDTH-1:0] data_q;
   logic [SEL_W-1:0] sel_q;

   assign req     = bus.in_valid & bus.ch_en;
   assign load_en = !valid_q || bus.out_ready;

   // First requester scanning upward from ptr (round-robin) or from 0.
   always_comb begin
      int idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = bus.prio_mode ? k : (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = SEL_W'(idx);
         end
      end
   end

   // Data of the winning channel.
   always_comb begin
      pick = '0;
      for (int i = 0; i < N; i++) begin
         if (win == SEL_W'(i)) pick = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   assign bus.in_ready = (load_en && found && !rst) ? (ONE << win) : '0;

   // Output register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
         ptr     <= '0;
      end else if (load_en) begin
         if (found) begin
            valid_q <= 1'b1;
            data_q  <= pick;
            sel_q   <= win;
            if (!bus.prio_mode) begin
               ptr <= (int'(win) == N-1) ? '0 : win + 1'b1;
            end
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed vectors with literal expectations plus a
// queue-based reference model compared on every cycle.
module tb_rr_stream_mux;
   localparam int W = 8;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   rr_stream_mux_if #(.WIDTH(W), .N(N)) bus ();

   rr_stream_mux #(.WIDTH(W), .N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state.
   bit         armed = 1'b0;
   bit         m_valid;
   logic [7:0] m_data;
   int         m_sel;
   int         m_ptr;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Channels listed in search order; the first requesting one wins.
   function automatic void grant(output bit ok, output int idx);
      int order[$];
      ok  = 1'b0;
      idx = 0;
      for (int k = 0; k < N; k++)
         order.push_back(bus.prio_mode ? k : (m_ptr + k) % N);
      foreach (order[j]) begin
         if (!ok && bus.in_valid[order[j]] && bus.ch_en[order[j]]) begin
            ok  = 1'b1;
            idx = order[j];
         end
      end
   endfunction

   // Model update on the active edge.
   always @(posedge clk) begin
      bit ok;
      int idx;
      grant(ok, idx);
      if (rst) begin
         armed   <= 1'b1;
         m_valid <= 1'b0;
         m_data  <= 8'h00;
         m_sel   <= 0;
         m_ptr   <= 0;
      end else if (armed && (!m_valid || bus.out_ready)) begin
         if (ok) begin
            m_valid <= 1'b1;
            m_data  <= bus.in_data[idx*W +: W];
            m_sel   <= idx;
            if (!bus.prio_mode) m_ptr <= (idx + 1) % N;
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      bit         ok;
      int         idx;
      logic [3:0] er;
      if (armed) begin
         grant(ok, idx);
         er = 4'b0000;
         if (!rst && (!m_valid || bus.out_ready) && ok) er[idx] = 1'b1;
         chk("model in_ready", 32'(bus.in_ready), 32'(er));
         chk("model out_valid", 32'(bus.out_valid), 32'(m_valid));
         chk("model out_data", 32'(bus.out_data), 32'(m_data));
         chk("model out_sel", 32'(bus.out_sel), 32'(m_sel));
      end
   end

   task automatic set_data();
      for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 8'hA0 + 8'(i);
   endtask

   task automatic out_is(input string name, input logic v,
                         input logic [7:0] d, input logic [1:0] s);
      chk({name, " valid"}, 32'(bus.out_valid), 32'(v));
      chk({name, " data"}, 32'(bus.out_data), 32'(d));
      chk({name, " sel"}, 32'(bus.out_sel), 32'(s));
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 4'hF;
      bus.ch_en     = 4'hF;
      bus.prio_mode = 1'b0;
      bus.out_ready = 1'b1;
      set_data();

      // Reset and idle
      @(negedge clk);
      chk("rst ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      chk("rst ready2", 32'(bus.in_ready), 32'h0);
      out_is("rst", 1'b0, 8'h00, 2'd0);
      #1 rst = 1'b0;
      #1 chk("first grant", 32'(bus.in_ready), 32'h1);

      // Round-robin fairness
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         out_is("rr", 1'b1, 8'hA0 + 8'(k % 4), 2'(k % 4));
      end

      // Bubble, then load 5C on channel 2 and stall
      #1 bus.in_valid = 4'h0;
      bus.in_data[2*W +: W] = 8'h5C;
      @(negedge clk);
      chk("idle valid", 32'(bus.out_valid), 32'h0);
      #1 bus.in_valid = 4'hF;
      @(negedge clk);
      out_is("load", 1'b1, 8'h5C, 2'd2);
      #1 bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         out_is("stall", 1'b1, 8'h5C, 2'd2);
         chk("stall ready", 32'(bus.in_ready), 32'h0);
      end
      #1 bus.out_ready = 1'b1;
      #1 chk("release grant", 32'(bus.in_ready), 32'h8);
      @(negedge clk);
      out_is("release", 1'b1, 8'hA3, 2'd3);

      // Fixed priority with mask, ptr left at 3
      #1 bus.in_valid = 4'b0100;
      @(negedge clk);
      out_is("ch2 rr", 1'b1, 8'h5C, 2'd2);
      #1 bus.prio_mode = 1'b1;
      bus.in_valid = 4'b1110;
      bus.ch_en    = 4'b1101;
      #1 chk("prio grant", 32'(bus.in_ready), 32'h4);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         out_is("prio", 1'b1, 8'h5C, 2'd2);
         chk("prio ready", 32'(bus.in_ready), 32'h4);
      end
      #1 bus.prio_mode = 1'b0;
      #1 chk("back to rr", 32'(bus.in_ready), 32'h8);
      @(negedge clk);
      out_is("rr ptr3", 1'b1, 8'hA3, 2'd3);

      // Sparse and wrap
      #1 bus.ch_en = 4'hF;
      bus.in_valid = 4'b1000;
      @(negedge clk);
      out_is("only3", 1'b1, 8'hA3, 2'd3);
      #1 bus.in_valid = 4'b0001;
      @(negedge clk);
      out_is("only0", 1'b1, 8'hA0, 2'd0);
      #1 bus.in_valid = 4'b0000;
      @(negedge clk);
      chk("drain valid", 32'(bus.out_valid), 32'h0);
      #1 bus.in_valid = 4'hF;
      #1 chk("ptr1 grant", 32'(bus.in_ready), 32'h2);
      @(negedge clk);
      out_is("ptr1", 1'b1, 8'hA1, 2'd1);

      // Reset while stalled
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      out_is("hold", 1'b1, 8'hA1, 2'd1);
      #1 rst = 1'b1;
      #1 chk("rst mid ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      out_is("rst mid", 1'b0, 8'h00, 2'd0);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      #1 chk("post rst grant", 32'(bus.in_ready), 32'h1);
      @(negedge clk);
      out_is("post rst", 1'b1, 8'hA0, 2'd0);

      @(negedge clk);
      #2 $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-input, W-bit stream multiplexer with valid/ready handshakes, a per-channel enable mask, selectable round-robin or fixed-priority arbitration, and a registered output stage. It is the sequential, multi-channel successor to the plain 2:1 select mux. It sits wherever several producers share one downstream consumer, for example bus funnels and debug trace merging. Selection is made by the arbiter, not by an external select line.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- N, 4, number of input channels (≥2)
- SEL_W, derived = max(1, $clog2(N)), width of the channel index; not overridden
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  reset; synchronous and active-high
- in_valid  input  N  per-channel valid
- in_data  input  N*WIDTH  channel i occupies [i*WIDTH +: WIDTH]
- in_ready  output  N  per-channel ready; combinational
- ch_en  input  N  channel enable mask; a 0 bit excludes that channel from arbitration
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered data
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  downstream accepts the beat

## Operation
- load_en = !out_valid || out_ready. The output register may load a new beat this cycle.
- Candidate set: req[i] = in_valid[i] && ch_en[i].
- Round-robin (prio_mode=0): the winner is the first set req bit searching from index ptr upward, wrapping at N-1 → 0.
- Fixed priority (prio_mode=1): the winner is the lowest set req bit. ptr is ignored and not modified.
- in_ready[i] = load_en && (req != 0) && (winner == i). At most one bit is set. A channel with ch_en[i]=0 always has in_ready[i]=0.
- Accept (input i transfers) when in_valid[i] && in_ready[i]. On the next edge:
  - out_data ← in_data[i]
  - out_sel ← i
  - out_valid ← 1
  - in round-robin mode, ptr ← (i+1) mod N
- load_en && req==0: out_valid ← 0. out_data and out_sel hold their last values.
- out_valid && !out_ready: out_valid, out_data and out_sel hold. Every in_ready is 0.
- Full throughput: with out_ready held at 1 and req nonzero, one beat transfers every cycle.
- ptr changes only on an accept made in round-robin mode.
- Changes to prio_mode and ch_en are combinational and affect the current cycle's arbitration. A mode change never corrupts the beat already in the register.
- No ordering guarantee exists across channels. Ordering within a channel is preserved.

## Timing
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_sel=0, ptr=0. While rst=1 every in_ready is 0.
- Reset asserted while out_valid=1 and stalled: the beat is discarded. No beat is accepted in that cycle.
- Latency: an input accepted at edge k appears on out_data/out_valid after edge k, so it is visible in cycle k+1.
- in_ready has a combinational path from out_ready, in_valid, ch_en and prio_mode. There is no combinational path from any input to out_valid, out_data or out_sel.
- Round-robin wrap: after a grant to N-1, ptr=0.
- Only channel i requesting: it is granted every cycle regardless of ptr.
- Simultaneous downstream pop and upstream accept in the same cycle: the register is overwritten and out_valid stays 1. No bubble is inserted.
- Producers must hold in_valid and in_data stable until accepted. The block does not check this.

## Test plan
- Reset/idle: assert rst for 2 cycles with all in_valid=1. Require in_ready=0, out_valid=0, out_data=0, out_sel=0. After release, the first grant is channel 0.
- Round-robin fairness: N=4, all valid, ch_en=4'hF, out_ready=1, in_data[i]=8'hA0+i. Require out_sel sequence 0,1,2,3,0,1, one beat per cycle, out_data=A0,A1,A2,A3,A0,A1.
- Backpressure: hold out_ready=0 for 3 cycles with a beat loaded (out_data=8'h5C, out_sel=2). Require out_data, out_sel and out_valid stable and in_ready=0. On release, the next grant is channel 3.
- Fixed priority and mask: prio_mode=1, in_valid=4'b1110, ch_en=4'b1101. Require channel 2 granted repeatedly, and channels 1 and 0 never granted. Switch to prio_mode=0 with ptr=3: the next grant is 3.
- Sparse/wrap: only channel 3 valid, then only channel 0. Require grants 3 then 0 with ptr=1 afterwards. When in_valid drops to 0 with out_ready=1, require out_valid=0 on the next cycle.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0. Require out_valid=0 after the edge and ptr=0. Verify by granting channel 0 first after release with all valid.
